// File: rtl/nes_pkg.sv
// Shared NES memory-map constants and the OAM DMA sequencer state type.
package nes_pkg;

  localparam logic [15:0] PPU_REG_BASE = 16'h2000;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    GET,
    PUT
  } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA: on a $4014 write, halts the 6502 and copies page P into
// OAMDATA with alternating get/put CPU cycles, gets always on even cycles.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = nes_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        dma_we,
  input  logic [7:0]  mem_din,
  output logic [7:0]  dma_dout,
  output logic        dma_done
);

  nes_pkg::dma_state_t state;
  logic       odd;
  logic [7:0] idx;
  logic [7:0] page_q;
  logic [7:0] data_q;
  logic       trigger;

  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= nes_pkg::IDLE;
      odd      <= 1'b0;
      idx      <= 8'h00;
      page_q   <= 8'h00;
      data_q   <= 8'h00;
      dma_done <= 1'b0;
    end else if (cpu_ce) begin
      odd      <= ~odd;
      dma_done <= 1'b0;
      unique case (state)
        nes_pkg::IDLE: begin
          if (trigger) begin
            state  <= nes_pkg::HALT;
            page_q <= cpu_dout;
            idx    <= 8'h00;
          end
        end
        // An odd HALT cycle means the next cycle is even and can be a get.
        nes_pkg::HALT:  state <= odd ? nes_pkg::GET : nes_pkg::ALIGN;
        nes_pkg::ALIGN: state <= nes_pkg::GET;
        nes_pkg::GET:   state <= nes_pkg::PUT;
        nes_pkg::PUT: begin
          data_q <= mem_din;
          idx    <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state    <= nes_pkg::IDLE;
            dma_done <= 1'b1;
          end else begin
            state <= nes_pkg::GET;
          end
        end
        default: state <= nes_pkg::IDLE;
      endcase
    end
  end

  assign cpu_halt   = (state != nes_pkg::IDLE);
  assign dma_active = (state != nes_pkg::IDLE);
  assign dma_rd     = (state == nes_pkg::GET);
  assign dma_we     = (state == nes_pkg::PUT);

  always_comb begin
    dma_addr = 16'h0000;
    dma_dout = 8'h00;
    if (state == nes_pkg::GET) begin
      dma_addr = {page_q, idx};
    end else if (state == nes_pkg::PUT) begin
      dma_addr = OAMDATA_ADDR;
      dma_dout = mem_din;
    end
  end

endmodule
